// File: rtl/dense_layer_engine.sv
// Single-MAC fully-connected layer: buffers one input vector, then computes each
// neuron from ROM weights/bias, requantises, activates and streams the result out.
module dense_layer_engine #(
  parameter int unsigned IN_SIZE      = 2,
  parameter int unsigned OUT_SIZE     = 3,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned WFRAC        = 7,
  parameter int unsigned ACC_WIDTH    = 32,
  localparam int unsigned W_AW = $clog2(IN_SIZE * OUT_SIZE),
  localparam int unsigned B_AW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              act_mode,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [W_AW-1:0]         w_addr,
  input  logic [WEIGHT_WIDTH-1:0] w_data,
  output logic [B_AW-1:0]         b_addr,
  input  logic [DATA_WIDTH-1:0]   b_data,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    done
);

  localparam int unsigned I_W = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int unsigned PW  = DATA_WIDTH + WEIGHT_WIDTH;
  localparam int unsigned RND = 1 << (WFRAC - 1);

  localparam logic [I_W-1:0]  LAST_I = I_W'(IN_SIZE - 1);
  localparam logic [B_AW-1:0] LAST_O = B_AW'(OUT_SIZE - 1);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    ACC_WIDTH'({1'b0, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic signed [DATA_WIDTH-1:0] HT_MAX = DATA_WIDTH'(256);
  localparam logic signed [DATA_WIDTH-1:0] HT_MIN = -HT_MAX;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_RESULT, S_OUT} state_t;

  state_t state, state_next;

  logic signed [DATA_WIDTH-1:0] in_buf [IN_SIZE];
  logic [I_W-1:0]               wr_idx;
  logic [1:0]                   mode_q;
  logic                         iss_v, rd_v;
  logic [I_W-1:0]               iss_k, rd_k;
  logic signed [ACC_WIDTH-1:0]  acc;

  logic accept, last_in, hs, last_out, start_mac, in_ready_next, done_next;

  logic signed [PW-1:0]         prod;
  logic signed [ACC_WIDTH-1:0]  bias_ext, rnd, shr;
  logic signed [DATA_WIDTH-1:0] sat, act;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake strobes
  always_comb begin
    state_next    = state;
    accept        = 1'b0;
    last_in       = 1'b0;
    hs            = 1'b0;
    last_out      = (b_addr == LAST_O);
    start_mac     = 1'b0;
    in_ready_next = 1'b0;
    done_next     = 1'b0;
    case (state)
      S_IDLE, S_LOAD: begin
        accept        = in_ready && in_valid;
        last_in       = accept && (wr_idx == LAST_I);
        in_ready_next = !last_in;
        start_mac     = last_in;
        if (last_in)     state_next = S_MAC;
        else if (accept) state_next = S_LOAD;
      end
      S_MAC: begin
        if (rd_v && (rd_k == LAST_I)) state_next = S_RESULT;
      end
      S_RESULT: state_next = S_OUT;
      S_OUT: begin
        hs = out_valid && out_ready;
        if (hs) begin
          if (last_out) begin
            state_next    = S_IDLE;
            in_ready_next = 1'b1;
            done_next     = 1'b1;
          end else begin
            state_next = S_MAC;
            start_mac  = 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // MAC operands, requantisation and activation
  always_comb begin
    prod     = PW'(in_buf[rd_k]) * PW'($signed(w_data));
    bias_ext = ACC_WIDTH'($signed(b_data)) <<< WFRAC;
    rnd      = acc + ACC_WIDTH'(RND);
    shr      = rnd >>> WFRAC;
    if (shr > SAT_MAX)      sat = DATA_WIDTH'(SAT_MAX);
    else if (shr < SAT_MIN) sat = DATA_WIDTH'(SAT_MIN);
    else                    sat = DATA_WIDTH'(shr);
    act = sat;
    case (mode_q)
      2'd1: if (sat[DATA_WIDTH-1]) act = '0;
      2'd2: if (sat[DATA_WIDTH-1]) act = sat >>> 3;
      2'd3: begin
        if (sat > HT_MAX)      act = HT_MAX;
        else if (sat < HT_MIN) act = HT_MIN;
      end
      default: act = sat;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < IN_SIZE; j++) in_buf[j] <= '0;
      wr_idx    <= '0;
      mode_q    <= '0;
      iss_v     <= 1'b0;
      iss_k     <= '0;
      rd_v      <= 1'b0;
      rd_k      <= '0;
      acc       <= '0;
      w_addr    <= '0;
      b_addr    <= '0;
      in_ready  <= 1'b0;
      done      <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      in_ready <= in_ready_next;
      done     <= done_next;

      if (accept) begin
        in_buf[wr_idx] <= in_data;
        wr_idx         <= last_in ? '0 : wr_idx + I_W'(1);
        if (wr_idx == '0) mode_q <= act_mode;
      end

      // Address walk: neuron base on entry, then one weight per cycle
      if (last_in) begin
        w_addr <= '0;
        b_addr <= '0;
      end else if (hs && !last_out) begin
        w_addr <= w_addr + W_AW'(1);
        b_addr <= b_addr + B_AW'(1);
      end else if (iss_v && (iss_k != LAST_I)) begin
        w_addr <= w_addr + W_AW'(1);
      end

      if (start_mac) begin
        iss_v <= 1'b1;
        iss_k <= '0;
      end else if (iss_v) begin
        if (iss_k == LAST_I) iss_v <= 1'b0;
        else                 iss_k <= iss_k + I_W'(1);
      end

      // ROM data lags the address by one cycle
      rd_v <= iss_v;
      rd_k <= iss_k;
      if (rd_v) acc <= ((rd_k == '0) ? bias_ext : acc) + ACC_WIDTH'(prod);

      if (state == S_RESULT) begin
        out_data  <= act;
        out_valid <= 1'b1;
      end else if (hs) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/dense_layer_engine.md
Name: dense_layer_engine

Overview:
- Parametrised, single-MAC fully-connected layer engine; successor to the fixed 2->3->9 generator datapath.
- Streams in one IN_SIZE-vector of Q8.8 activations and reads int8 Q1.7 weights and Q8.8 biases from an external synchronous ROM.
- Streams out OUT_SIZE Q8.8 results through a run-time-selectable activation: linear, ReLU, leaky ReLU or hard-tanh.
- Instances are chained to build generator and discriminator MLPs of arbitrary shape.

Parameters:
IN_SIZE, 2, input vector length (>=1)
OUT_SIZE, 3, output neurons (>=1); IN_SIZE*OUT_SIZE >= 2
DATA_WIDTH, 16, activation/bias width, Q8.8
WEIGHT_WIDTH, 8, weight width, signed, WFRAC fractional bits
WFRAC, 7, weight fractional bits (requant shift)
ACC_WIDTH, 32, accumulator width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
act_mode  in  2  0=linear, 1=ReLU, 2=leaky (x>>>3 for x<0), 3=hard-tanh (clamp to [-256,+256])
in_data  in  DATA_WIDTH  signed input activation
in_valid  in  1  in_data valid
in_ready  out  1  engine accepts input word
w_addr  out  clog2(IN_SIZE*OUT_SIZE)  weight ROM address = o*IN_SIZE+i
w_data  in  WEIGHT_WIDTH  weight, valid 1 cycle after w_addr
b_addr  out  clog2(OUT_SIZE) (min 1)  bias ROM address = o
b_data  in  DATA_WIDTH  bias, valid 1 cycle after b_addr
out_data  out  DATA_WIDTH  activated result, neuron order 0..OUT_SIZE-1
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data
done  out  1  one-cycle pulse after last output accepted

Behaviour:
- Reset (rst=1 at edge): state=IDLE; in_ready=0 during reset; out_valid=0, done=0, out_data=0, w_addr=0, b_addr=0, all indices and accumulator=0. Reset mid-operation abandons the vector; no partial output.
- IDLE/LOAD: in_ready=1. Each in_valid&in_ready edge stores in_data at buf[i], i++. act_mode is latched on the first accepted word of a vector. When word IN_SIZE-1 is accepted: in_ready drops the next cycle, o=0, state->MAC.
- MAC, per neuron o, cycle k=0..IN_SIZE-1: drive w_addr=o*IN_SIZE+k; at k=0 also drive b_addr=o.
  - Data returns one cycle later; pipeline registers track the matching buf index.
  - First returning cycle: acc = (b_data sign-extended <<< WFRAC) + buf[0]*w_data.
  - Later cycles: acc += buf[k]*w_data.
  - Products are full-precision signed (DATA_WIDTH+WEIGHT_WIDTH bits), sign-extended to ACC_WIDTH.
- RESULT (one cycle after last data returns):
  - r = (acc + 2^(WFRAC-1)) >>> WFRAC (round half up), then saturate to DATA_WIDTH signed range [-32768, 32767].
  - Apply act_mode. Leaky uses arithmetic shift (floor). Hard-tanh clamps to [-256, 256].
  - Register into out_data; out_valid=1; state->OUT.
- Latency: out_valid for neuron 0 rises on edge IN_SIZE+2 after the edge accepting the last input word. Each subsequent neuron's out_valid rises IN_SIZE+2 edges after the previous handshake.
- OUT: out_data and out_valid held stable until out_ready=1; no ROM address advance while stalled. On handshake: out_valid=0 next cycle.
  - If o<OUT_SIZE-1: o++, state->MAC.
  - Else: done=1 for one cycle, state->IDLE, in_ready=1 the same cycle done is high.
- in_valid while in_ready=0 is ignored; no input data is buffered during compute.
- Intermediate accumulator overflow wraps at ACC_WIDTH; saturation applies only at requant. Defaults cannot overflow.
- Weights and biases are never cached; every neuron re-reads the ROM.

Test Plan:
1. Default params, linear mode, inputs [395,22], weights [7,11,23,4,-29,-17], biases 0, out_ready=1 -> outputs 23, 72, -92 in order; first out_valid exactly IN_SIZE+2=4 edges after last input accept; single done pulse.
2. Same vectors, act_mode=1 -> 23, 72, 0. act_mode=2 -> 23, 72, -12.
3. Saturation: inputs [32767,32767], all weights 127. Linear -> 32767 for every neuron; hard-tanh -> 256. Inputs [-32768,-32768] with hard-tanh -> -256.
4. Bias path: inputs 0, biases [256,-128,1] -> linear outputs 256, -128, 1. ReLU -> 256, 0, 1.
5. Backpressure: out_ready=0 for 5 cycles on neuron 1 -> out_data stays 72, out_valid stays 1, w_addr frozen. Release -> neuron 2 = -92 with correct latency; in_valid pulses during compute are ignored.
6. Reset mid-MAC on neuron 1 -> next cycle out_valid=0, done=0, in_ready=1 after rst drops. Fresh vector from test 1 reproduces 23, 72, -92.
